merge_two: RTL and testbench



---
 rtl/merge_two.sv | 103 ++++++++++
 tb/tb_merge_two.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/merge_two.sv
// merge_two: assembles four 2-bit PPM symbols (LSB dibit first) into a byte,
// discarding a partial byte with a framing-error pulse after a symbol gap timeout.
`default_nettype none

module merge_two #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] sym_in,
  input  logic       sym_valid,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, GOT1 = 2'd1, GOT2 = 2'd2, GOT3 = 2'd3} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nx;
  logic [5:0]       sh, sh_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [7:0]       data_nx;
  logic             dv_nx, fe_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sh         <= '0;
      cnt        <= '0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      sh         <= sh_nx;
      cnt        <= cnt_nx;
      data_out   <= data_nx;
      data_valid <= dv_nx;
      frame_err  <= fe_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sh_nx    = sh;
    cnt_nx   = cnt;
    data_nx  = data_out;
    dv_nx    = 1'b0;
    fe_nx    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (sym_valid) begin
          sh_nx    = {4'b0000, sym_in};
          state_nx = GOT1;
        end
      end
      GOT1, GOT2, GOT3: begin
        if (sym_valid) begin
          // An accepted symbol wins over a timeout landing on the same cycle.
          cnt_nx = '0;
          case (state)
            GOT1: begin
              sh_nx[3:2] = sym_in;
              state_nx   = GOT2;
            end
            GOT2: begin
              sh_nx[5:4] = sym_in;
              state_nx   = GOT3;
            end
            default: begin
              data_nx  = {sym_in, sh};
              dv_nx    = 1'b1;
              sh_nx    = '0;
              state_nx = IDLE;
            end
          endcase
        end else if (cnt == LAST_CNT) begin
          fe_nx    = 1'b1;
          sh_nx    = '0;
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        sh_nx    = '0;
        cnt_nx   = '0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_merge_two.sv
// Randomized self-checking bench for merge_two against a symbol-counting reference model.
`default_nettype none

module tb_merge_two;

  localparam int TIMEOUT = 256;
  localparam int CNT_W   = 9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sym_in = 2'b00;
  logic       sym_valid = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, frame_err, busy;

  merge_two #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .sym_in(sym_in), .sym_valid(sym_valid),
    .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: dibits held so far, byte under construction, idle clocks since last symbol.
  int         m_n = 0;
  logic [7:0] m_acc = 8'h00;
  logic [7:0] m_data = 8'h00;
  bit         m_dv = 1'b0;
  bit         m_fe = 1'b0;
  int         m_gap = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_acc = 8'h00; m_data = 8'h00; m_dv = 1'b0; m_fe = 1'b0; m_gap = 0;
  endtask

  // One clock: drive inputs, advance model at the edge, compare all outputs just after it.
  task automatic tick(input bit sv, input logic [1:0] s, input string tag);
    sym_valid = sv;
    sym_in    = sv ? s : 2'($urandom);
    @(posedge clk);
    m_dv = 1'b0;
    m_fe = 1'b0;
    if (sv) begin
      m_acc = m_acc | (8'(s) << (2 * m_n));
      m_n++;
      m_gap = 0;
      if (m_n == 4) begin
        m_data = m_acc; m_dv = 1'b1; m_n = 0; m_acc = 8'h00;
      end
    end else if (m_n > 0) begin
      m_gap++;
      if (m_gap == TIMEOUT) begin
        m_fe = 1'b1; m_n = 0; m_acc = 8'h00; m_gap = 0;
      end
    end
    #1;
    check(tag, {21'd0, data_out, data_valid, frame_err, busy},
          {21'd0, m_data, m_dv, m_fe, (m_n > 0)});
    sym_valid = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(1'b0, 2'b00, tag);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input string tag);
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, b[2*k +: 2], tag);
      if (k < 3) idle(gap, tag);
    end
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check(tag, {21'd0, data_out, data_valid, frame_err, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] b;
    int         gap;
    #1;
    check("reset_state", {21'd0, data_out, data_valid, frame_err, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3, "post_reset");

    send_byte(8'hB4, 127, "byte_b4");
    check("b4_value", {24'd0, data_out}, 32'h0000_00B4);
    idle(5, "b4_after");

    send_byte(8'hFF, 0, "b2b_ff");
    check("b2b_ff_value", {24'd0, data_out}, 32'h0000_00FF);
    send_byte(8'h00, 0, "b2b_00");
    check("b2b_00_value", {24'd0, data_out}, 32'h0000_0000);

    tick(1'b1, 2'b01, "to_sym");
    tick(1'b1, 2'b10, "to_sym");
    idle(TIMEOUT - 1, "to_wait");
    tick(1'b0, 2'b00, "to_fire");
    check("to_frame_err", {31'd0, frame_err}, 32'd1);
    idle(20, "to_after");
    send_byte(8'h5A, 3, "byte_5a");
    check("5a_value", {24'd0, data_out}, 32'h0000_005A);

    tick(1'b1, 2'b11, "bnd_sym1");
    idle(TIMEOUT - 1, "bnd_wait");
    tick(1'b1, 2'b00, "bnd_sym2");
    check("bnd_no_err", {31'd0, frame_err}, 32'd0);
    tick(1'b1, 2'b01, "bnd_sym3");
    tick(1'b1, 2'b10, "bnd_sym4");
    check("bnd_value", {24'd0, data_out}, 32'h0000_0093);

    tick(1'b1, 2'b01, "rst_sym");
    tick(1'b1, 2'b01, "rst_sym");
    tick(1'b1, 2'b01, "rst_sym");
    do_reset("mid_reset");
    send_byte(8'h3C, 2, "byte_3c");
    check("3c_value", {24'd0, data_out}, 32'h0000_003C);

    idle(10 * TIMEOUT, "long_idle");
    check("idle_hold", {24'd0, data_out}, 32'h0000_003C);

    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 3))
        0: gap = 0;
        1: gap = $urandom_range(1, 20);
        2: gap = $urandom_range(TIMEOUT - 2, TIMEOUT + 2);
        default: gap = $urandom_range(100, 140);
      endcase
      idle(gap, "rand_gap");
      b = 8'($urandom);
      tick(1'b1, b[1:0], "rand_sym");
    end
    idle(TIMEOUT + 5, "rand_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
